// File: rtl/zuc_ks_responder.sv
// zuc_ks_responder: serves upstream 128-bit keystream blocks as 32-bit words over the zuc_core handshake
module zuc_ks_responder #(
  parameter int BLK_DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_init,
  input  logic [127:0] i_key,
  input  logic [127:0] i_iv,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [31:0]  o_data,
  output logic         o_req,
  output logic [127:0] o_req_key,
  output logic [127:0] o_req_iv,
  input  logic         i_req_ack,
  input  logic         i_blk_valid,
  input  logic [127:0] i_blk_data,
  output logic         o_blk_ready,
  output logic         o_underrun
);
  localparam int PW = $clog2(BLK_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, RUN} state_t;
  state_t state, state_nx;
  logic [127:0] mem [BLK_DEPTH];
  logic [127:0] head;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [1:0] widx;
  logic wr, rd, pop;
  // state register
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_nx;
  // next state: init restarts the session from any state
  always_comb state_nx = i_init ? REQ : state == IDLE ? IDLE : state == REQ ? (i_req_ack ? RUN : REQ) : RUN;
  // outputs and handshake qualifiers, all derived from registered state
  always_comb begin
    o_req = state == REQ;
    o_blk_ready = state == RUN && cnt < (PW+1)'(BLK_DEPTH);
    o_valid = state == RUN && cnt != '0;
    head = mem[rp];
    o_data = !o_valid ? '0 : widx == 2'd0 ? head[127:96] : widx == 2'd1 ? head[95:64] : widx == 2'd2 ? head[63:32] : head[31:0];
    wr = !i_init && i_blk_valid && o_blk_ready;
    rd = !i_init && o_valid && i_ready;
    pop = rd && widx == 2'd3;
  end
  // block storage
  always_ff @(posedge i_clk) if (wr) mem[wp] <= i_blk_data;
  // session latch, buffer pointers, word index and underrun flag
  always_ff @(posedge i_clk) begin
    if (i_rst || i_init) begin
      o_req_key <= i_rst ? '0 : i_key;
      o_req_iv <= i_rst ? '0 : i_iv;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      widx <= '0;
      o_underrun <= 1'b0;
    end else begin
      wp <= wp + PW'(wr);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(wr) - (PW+1)'(pop);
      widx <= widx + 2'(rd);
      if (state == RUN && i_ready && !o_valid) o_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_zuc_ks_responder.sv
// tb_zuc_ks_responder: directed self-checking bench for zuc_ks_responder
module tb_zuc_ks_responder;
  logic clk = 1'b0;
  logic rst, init, ready, req_ack, blk_valid;
  logic [127:0] key, iv, blk_data;
  logic valid, req, blk_ready, underrun;
  logic [31:0] data;
  logic [127:0] req_key, req_iv;
  int vecs = 0;
  int errs = 0;
  localparam logic [127:0] K1 = 128'h3d4c4be96a82fdaeb58f641db17b455b;
  localparam logic [127:0] V1 = 128'h84319aa8de6915ca1f6bda6bfbd8c766;
  localparam logic [127:0] K2 = 128'h0123456789abcdef0011223344556677;
  localparam logic [127:0] V2 = 128'hfedcba98765432108899aabbccddeeff;

  zuc_ks_responder dut (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_key(key), .i_iv(iv), .i_ready(ready),
    .o_valid(valid), .o_data(data), .o_req(req), .o_req_key(req_key), .o_req_iv(req_iv),
    .i_req_ack(req_ack), .i_blk_valid(blk_valid), .i_blk_data(blk_data),
    .o_blk_ready(blk_ready), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [127:0] k, input logic [127:0] v);
    init = 1; key = k; iv = v;
    tick();
    init = 0; req_ack = 1;
    tick();
    req_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1; init = 0; ready = 0; req_ack = 0; blk_valid = 0; key = '0; iv = '0; blk_data = '0;
    tick(); tick();
    rst = 0;
    vecs++;
    if ({valid, data, req, req_key, req_iv, blk_ready, underrun} !== '0) begin
      errs++;
      $display("FAIL reset: outputs v=%b d=%h req=%b k=%h iv=%h br=%b ur=%b, all required 0", valid, data, req, req_key, req_iv, blk_ready, underrun);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    init = 1; key = K1; iv = V1;
    tick();
    init = 0; key = '0; iv = '0;
    vecs++;
    if (req !== 1'b1 || req_key !== K1 || req_iv !== V1) begin
      errs++;
      $display("FAIL basic_req: req=%b key=%h iv=%h, required 1 %h %h", req, req_key, req_iv, K1, V1);
    end
    tick(); tick();
    vecs++;
    if (req !== 1'b1 || blk_ready !== 1'b0) begin
      errs++;
      $display("FAIL basic_req_hold: req=%b blk_ready=%b, required 1 0", req, blk_ready);
    end
    req_ack = 1;
    tick();
    req_ack = 0;
    vecs++;
    if (req !== 1'b0 || blk_ready !== 1'b1 || valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_run: req=%b blk_ready=%b valid=%b, required 0 1 0", req, blk_ready, valid);
    end
    blk_valid = 1; blk_data = 128'h11111111_22222222_33333333_44444444;
    tick();
    blk_valid = 0; ready = 1;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (valid !== 1'b1 || data !== exp[i]) begin
        errs++;
        $display("FAIL basic_word%0d: valid=%b data=%h, required 1 %h", i, valid, data, exp[i]);
      end
      tick();
    end
    ready = 0;
    vecs++;
    if (valid !== 1'b0 || data !== 32'h0 || underrun !== 1'b0) begin
      errs++;
      $display("FAIL basic_drained: valid=%b data=%h underrun=%b, required 0 0 0", valid, data, underrun);
    end
  endtask

  task automatic test_full();
    logic [127:0] blk [3] = '{128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3,
                             128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3,
                             128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3};
    logic [127:0] b;
    logic [31:0] e;
    start_session(K2, V2);
    for (int i = 0; i < 2; i++) begin
      blk_valid = 1; blk_data = blk[i];
      vecs++;
      if (blk_ready !== 1'b1) begin
        errs++;
        $display("FAIL full_accept%0d: blk_ready=%b, required 1", i, blk_ready);
      end
      tick();
    end
    blk_data = blk[2];
    vecs++;
    if (blk_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_block_c: blk_ready=%b, required 0", blk_ready);
    end
    tick();
    ready = 1;
    for (int i = 0; i < 12; i++) begin
      b = blk[i/4];
      e = 32'(b >> (96 - 32*(i%4)));
      vecs++;
      if (valid !== 1'b1 || data !== e) begin
        errs++;
        $display("FAIL full_word%0d: valid=%b data=%h, required 1 %h", i, valid, data, e);
      end
      if (i <= 3 || i == 5) begin
        vecs++;
        if (blk_ready !== 1'b0) begin
          errs++;
          $display("FAIL full_ready_low%0d: blk_ready=%b, required 0", i, blk_ready);
        end
      end
      if (i == 4) begin
        vecs++;
        if (blk_ready !== 1'b1) begin
          errs++;
          $display("FAIL full_ready_rise: blk_ready=%b, required 1", blk_ready);
        end
      end
      tick();
      if (i == 4) blk_valid = 0;
    end
    ready = 0;
    vecs++;
    if (valid !== 1'b0) begin
      errs++;
      $display("FAIL full_drained: valid=%b, required 0", valid);
    end
  endtask

  task automatic test_underrun();
    start_session(K1, V1);
    ready = 1;
    tick();
    ready = 0;
    vecs++;
    if (underrun !== 1'b1 || valid !== 1'b0) begin
      errs++;
      $display("FAIL underrun_set: underrun=%b valid=%b, required 1 0", underrun, valid);
    end
    blk_valid = 1; blk_data = 128'hdeadbeef_01020304_05060708_090a0b0c;
    tick();
    blk_valid = 0; ready = 1;
    vecs++;
    if (data !== 32'hdeadbeef) begin
      errs++;
      $display("FAIL underrun_data: data=%h, required deadbeef", data);
    end
    tick();
    ready = 0;
    vecs++;
    if (underrun !== 1'b1 || data !== 32'h01020304) begin
      errs++;
      $display("FAIL underrun_sticky: underrun=%b data=%h, required 1 01020304", underrun, data);
    end
    init = 1; key = K2; iv = V2;
    tick();
    init = 0;
    vecs++;
    if (underrun !== 1'b0) begin
      errs++;
      $display("FAIL underrun_clear: underrun=%b, required 0", underrun);
    end
    req_ack = 1;
    tick();
    req_ack = 0;
  endtask

  task automatic test_reinit();
    start_session(K1, V1);
    blk_valid = 1; blk_data = 128'h10000000_10000001_10000002_10000003;
    tick();
    blk_data = 128'h20000000_20000001_20000002_20000003;
    tick();
    blk_valid = 0; ready = 1;
    tick(); tick();
    vecs++;
    if (data !== 32'h10000002) begin
      errs++;
      $display("FAIL reinit_pre: data=%h, required 10000002", data);
    end
    init = 1; key = K2; iv = V2;
    tick();
    init = 0; ready = 0;
    vecs++;
    if (valid !== 1'b0 || req !== 1'b1 || req_key !== K2 || req_iv !== V2) begin
      errs++;
      $display("FAIL reinit_req: valid=%b req=%b key=%h iv=%h, required 0 1 %h %h", valid, req, req_key, req_iv, K2, V2);
    end
    req_ack = 1;
    tick();
    req_ack = 0;
    vecs++;
    if (valid !== 1'b0 || blk_ready !== 1'b1) begin
      errs++;
      $display("FAIL reinit_flushed: valid=%b blk_ready=%b, required 0 1", valid, blk_ready);
    end
    blk_valid = 1; blk_data = 128'h30000000_30000001_30000002_30000003;
    tick();
    blk_valid = 0;
    vecs++;
    if (valid !== 1'b1 || data !== 32'h30000000) begin
      errs++;
      $display("FAIL reinit_new_word: valid=%b data=%h, required 1 30000000", valid, data);
    end
  endtask

  task automatic test_reset_mid();
    init = 1; key = K1; iv = V1;
    tick();
    init = 0;
    rst = 1;
    tick();
    rst = 0;
    vecs++;
    if ({valid, data, req, req_key, req_iv, blk_ready, underrun} !== '0) begin
      errs++;
      $display("FAIL reset_in_req: v=%b d=%h req=%b k=%h iv=%h br=%b ur=%b, all required 0", valid, data, req, req_key, req_iv, blk_ready, underrun);
    end
    start_session(K2, V2);
    blk_valid = 1; blk_data = 128'h40000000_40000001_40000002_40000003;
    tick();
    blk_valid = 0;
    rst = 1; init = 1; key = K1; iv = V1;
    tick();
    rst = 0; init = 0;
    vecs++;
    if ({valid, data, req, req_key, req_iv, blk_ready, underrun} !== '0) begin
      errs++;
      $display("FAIL reset_in_run: v=%b d=%h req=%b k=%h iv=%h br=%b ur=%b, all required 0", valid, data, req, req_key, req_iv, blk_ready, underrun);
    end
    blk_valid = 1; blk_data = 128'h50000000_50000001_50000002_50000003;
    req_ack = 1;
    tick();
    req_ack = 0;
    vecs++;
    if (blk_ready !== 1'b0 || valid !== 1'b0 || req !== 1'b0) begin
      errs++;
      $display("FAIL reset_ignore: blk_ready=%b valid=%b req=%b, required 0 0 0", blk_ready, valid, req);
    end
    blk_valid = 0;
    start_session(K1, V1);
    blk_valid = 1; blk_data = 128'h60000000_60000001_60000002_60000003;
    tick();
    blk_valid = 0;
    vecs++;
    if (data !== 32'h60000000) begin
      errs++;
      $display("FAIL reset_fresh: data=%h, required 60000000", data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_reinit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
